// File: rtl/sram_map_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sram_map_pkg
// Description : Shared SRAM region map and scan-out fetch state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package sram_map_pkg;

    localparam int unsigned LAYER1_BASE = 0;
    localparam int unsigned LAYER2_BASE = 65536;
    localparam int unsigned TEX1_BASE   = 131072;
    localparam int unsigned TEX2_BASE   = 135168;
    localparam int unsigned TEX3_BASE   = 139264;
    localparam int unsigned OUTPUT_BASE = 143360;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        REQ1      = 3'd1,
        REQ2      = 3'd2,
        CAPTURE   = 3'd3,
        HOLD      = 3'd4,
        DONE_WAIT = 3'd5
    } scan_state_t;

    // Exchange byte 0 and byte 2 of a 24-bit pixel (RGB <-> BGR).
    function automatic logic [23:0] swap_rb(input logic [23:0] p);
        return {p[7:0], p[15:8], p[23:16]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/scanout_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : scanout_line_buffer
// Description : Two-entry ping-pong block store; whole-block write, one-word
//               read, per-buffer full flags.
// Revision    : 1.0 - initial release
// ============================================================================
module scanout_line_buffer #(
    parameter int WORD_BITS = 24,
    parameter int DEPTH     = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic                       wr_sel,
    input  logic [WORD_BITS*DEPTH-1:0] wr_block,
    input  logic                       free_en,
    input  logic                       rd_sel,
    input  logic [$clog2(DEPTH)-1:0]   rd_idx,
    output logic [1:0]                 full,
    output logic [WORD_BITS-1:0]       rd_word
);

    logic [WORD_BITS*DEPTH-1:0] r_mem [2];
    logic [1:0]                 r_full;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_sel] <= wr_block;
        end
    end

    // Write and free target different buffers, so both may act in one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            if (wr_en) begin
                r_full[wr_sel] <= 1'b1;
            end
            if (free_en) begin
                r_full[rd_sel] <= 1'b0;
            end
        end
    end

    assign full    = r_full;
    assign rd_word = r_mem[rd_sel][int'(rd_idx) * WORD_BITS +: WORD_BITS];

endmodule
`default_nettype wire

// File: rtl/output_scanout.sv
`default_nettype none
// ============================================================================
// Module      : output_scanout
// Description : Fetches the composed frame from SRAM in blocks and streams it
//               one pixel per valid/ready beat. Optional SCANOUT_SWAP_RB_EN
//               swaps bytes 0 and 2 of every output pixel.
// Revision    : 1.0 - initial release
// ============================================================================
module output_scanout
    import sram_map_pkg::*;
#(
    parameter int ADDR_SIZE_BITS  = 24,
    parameter int WORD_SIZE_BYTES = 3,
    parameter int DATA_SIZE_WORDS = 64,
    parameter int BASE_ADDR       = int'(OUTPUT_BASE),
    parameter int FRAME_WORDS     = 65536
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        scan_en,
    output logic                                        scan_done,
    output logic                                        read_enable,
    output logic [ADDR_SIZE_BITS-1:0]                   address,
    input  logic [WORD_SIZE_BYTES*DATA_SIZE_WORDS*8-1:0] read_data,
    output logic                                        pix_valid,
    input  logic                                        pix_ready,
    output logic [WORD_SIZE_BYTES*8-1:0]                pix_data,
    output logic                                        pix_last
);

    localparam int PIX_W = WORD_SIZE_BYTES * 8;
    localparam int IDX_W = $clog2(DATA_SIZE_WORDS);
    localparam int OFF_W = $clog2(FRAME_WORDS) + 1;
    localparam int PC_W  = OFF_W - 1;
    localparam logic [OFF_W-1:0] BLK_STEP  = OFF_W'(DATA_SIZE_WORDS);
    localparam logic [OFF_W-1:0] FRAME_END = OFF_W'(FRAME_WORDS);
    localparam logic [PC_W-1:0]  LAST_PIX  = PC_W'(FRAME_WORDS - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_SIZE_WORDS - 1);

    scan_state_t      r_state;
    scan_state_t      w_next;
    logic [OFF_W-1:0] r_offset;
    logic [OFF_W-1:0] w_offset_next;
    logic [PC_W-1:0]  r_pix_cnt;
    logic [IDX_W-1:0] r_idx;
    logic             r_wr_sel;
    logic             r_rd_sel;
    logic             r_done;
    logic [1:0]       w_full;
    logic [PIX_W-1:0] w_word;
    logic [PIX_W-1:0] w_pix;
    logic             w_hs;
    logic             w_free;
    logic             w_start;
    logic             w_capture;
    logic             w_tgt;
    logic             w_tgt_free;

    scanout_line_buffer #(
        .WORD_BITS (PIX_W),
        .DEPTH     (DATA_SIZE_WORDS)
    ) u_line_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_capture),
        .wr_sel   (r_wr_sel),
        .wr_block (read_data),
        .free_en  (w_free),
        .rd_sel   (r_rd_sel),
        .rd_idx   (r_idx),
        .full     (w_full),
        .rd_word  (w_word)
    );

    assign w_hs          = pix_valid & pix_ready;
    assign w_free        = w_hs & (r_idx == LAST_IDX);
    assign w_start       = (r_state == IDLE) & scan_en;
    assign w_capture     = (r_state == CAPTURE);
    assign w_offset_next = r_offset + BLK_STEP;

    // Next buffer to fill; a buffer freed this cycle counts as available.
    assign w_tgt      = w_capture ? ~r_wr_sel : r_wr_sel;
    assign w_tgt_free = ~w_full[w_tgt] | (w_free & (r_rd_sel == w_tgt));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        read_enable = 1'b0;
        address     = '0;
        case (r_state)
            IDLE:      if (scan_en) w_next = REQ1;
            REQ1: begin
                read_enable = 1'b1;
                w_next      = REQ2;
            end
            REQ2: begin
                read_enable = 1'b1;
                w_next      = CAPTURE;
            end
            CAPTURE: begin
                if (w_offset_next == FRAME_END) w_next = DONE_WAIT;
                else if (w_tgt_free)            w_next = REQ1;
                else                            w_next = HOLD;
            end
            HOLD:      if (w_tgt_free) w_next = REQ1;
            DONE_WAIT: if (w_hs && pix_last) w_next = IDLE;
            default:   w_next = IDLE;
        endcase
        if (read_enable) begin
            address = ADDR_SIZE_BITS'(BASE_ADDR) + ADDR_SIZE_BITS'(r_offset);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_offset  <= '0;
            r_pix_cnt <= '0;
            r_idx     <= '0;
            r_wr_sel  <= 1'b0;
            r_rd_sel  <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= (r_state == DONE_WAIT) & w_hs & pix_last;
            if (w_start) begin
                r_offset  <= '0;
                r_pix_cnt <= '0;
                r_idx     <= '0;
                r_wr_sel  <= 1'b0;
                r_rd_sel  <= 1'b0;
            end
            if (w_capture) begin
                r_offset <= w_offset_next;
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_hs) begin
                r_pix_cnt <= r_pix_cnt + PC_W'(1);
                if (w_free) begin
                    r_idx    <= '0;
                    r_rd_sel <= ~r_rd_sel;
                end else begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end
        end
    end

`ifdef SCANOUT_SWAP_RB_EN
    assign w_pix = swap_rb(w_word);
`else
    assign w_pix = w_word;
`endif

    assign scan_done = r_done;
    assign pix_valid = w_full[r_rd_sel];
    assign pix_data  = pix_valid ? w_pix : '0;
    assign pix_last  = pix_valid & (r_pix_cnt == LAST_PIX);

endmodule
`default_nettype wire

// File: tb/tb_output_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_scanout
// Description : Self-checking bench for output_scanout with SRAM responder and
//               pixel-stream reference model (reduced frame size).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_scanout;

    localparam int ADDR_W   = 24;
    localparam int WB       = 3;
    localparam int DW       = 64;
    localparam int BASE     = 143360;
    localparam int FRAME    = 1024;
    localparam int NBLK     = FRAME / DW;
    localparam int BLK_BITS = WB * DW * 8;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                scan_en = 1'b0;
    logic                pix_ready = 1'b0;
    logic                scan_done;
    logic                read_enable;
    logic [ADDR_W-1:0]   address;
    logic [BLK_BITS-1:0] read_data = '0;
    logic                pix_valid;
    logic [23:0]         pix_data;
    logic                pix_last;

    output_scanout #(
        .ADDR_SIZE_BITS  (ADDR_W),
        .WORD_SIZE_BYTES (WB),
        .DATA_SIZE_WORDS (DW),
        .BASE_ADDR       (BASE),
        .FRAME_WORDS     (FRAME)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .scan_en     (scan_en),
        .scan_done   (scan_done),
        .read_enable (read_enable),
        .address     (address),
        .read_data   (read_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_last    (pix_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        re;
        logic [23:0] addr;
        logic        valid;
        logic [23:0] data;
    } vec_t;

    int          n_chk = 0;
    int          n_pass = 0;
    int          data_mode = 0;
    logic [31:0] salt = 32'h0;
    int          beat = 0;
    int          req_cnt = 0;
    int          done_cnt = 0;

    // Frame content as seen in SRAM, indexed by word offset within the frame.
    function automatic logic [23:0] word_at(input int unsigned off);
        logic [31:0] h;
        case (data_mode)
            0:       return off[23:0];
            1: begin
                h = (off * 32'h9E3779B1) ^ salt;
                return h[28:5];
            end
            default: return 24'h112233;
        endcase
    endfunction

    function automatic logic [23:0] exp_pix(input int unsigned off);
        logic [23:0] w;
        w = word_at(off);
`ifdef SCANOUT_SWAP_RB_EN
        return {w[7:0], w[15:8], w[23:16]};
`else
        return w;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // SRAM: data appears only in the cycle after a two-cycle request.
    logic re_d1 = 1'b0;
    always @(posedge clk) begin
        re_d1 <= read_enable;
        if (read_enable && re_d1) begin
            for (int k = 0; k < DW; k++)
                read_data[k*24 +: 24] <= word_at(int'(address) - BASE + k);
        end else begin
            read_data <= {(BLK_BITS/8){8'hA5}};
        end
    end

    // Reference model: expected request addresses and pixel stream.
    logic        re_p = 1'b0, re_p2 = 1'b0, stall_p = 1'b0, last_hs_p = 1'b0;
    logic [23:0] addr_p = '0;
    logic [24:0] hold_p = '0;
    always @(negedge clk) begin
        if (rst) begin
            beat = 0; req_cnt = 0; re_p = 0; re_p2 = 0; stall_p = 0; last_hs_p = 0;
        end else begin
            if (read_enable) begin
                if (!re_p) begin
                    chk("req_in_frame", req_cnt < NBLK, 1);
                    chk("req_addr", address, BASE + DW * req_cnt);
                    req_cnt++;
                end else begin
                    chk("req_addr_held", address, addr_p);
                    chk("req_len", re_p2, 0);
                end
            end else begin
                chk("addr_idle_zero", address, 0);
            end
            if (stall_p) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_hold", {pix_last, pix_data}, hold_p);
            end
            chk("scan_done", scan_done, last_hs_p);
            if (scan_done && last_hs_p) begin
                done_cnt++; beat = 0; req_cnt = 0;
            end
            last_hs_p = 0;
            if (pix_valid && pix_ready) begin
                chk("pix_data", pix_data, exp_pix(beat));
                chk("pix_last", pix_last, beat == FRAME - 1);
                last_hs_p = (beat == FRAME - 1);
                beat++;
            end
            stall_p = pix_valid && !pix_ready;
            hold_p  = {pix_last, pix_data};
            re_p2   = re_p;
            re_p    = read_enable;
            addr_p  = address;
        end
    end

    task automatic wait_done(input int limit, input bit rnd);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while (done_cnt == d0 && n < limit) begin
            tick();
            n++;
            if (rnd) pix_ready = ($urandom_range(3) != 0);
        end
        chk("frame_done", done_cnt - d0, 1);
        pix_ready = 1'b1;
    endtask

    task automatic start_scan();
        tick(); scan_en = 1'b1;
        tick(); scan_en = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int   cyc;
        int   n;
        int   d0;

        // Cycle-by-cycle startup expectation with pix_ready held high.
        data_mode = 0;
        for (int c = 0; c < 9; c++) begin
            tbl[c].re    = 1'b0;
            tbl[c].addr  = '0;
            tbl[c].valid = (c >= 4);
            tbl[c].data  = (c >= 4) ? exp_pix(c - 4) : 24'h0;
        end
        tbl[1].re = 1'b1; tbl[1].addr = BASE;
        tbl[2].re = 1'b1; tbl[2].addr = BASE;
        tbl[4].re = 1'b1; tbl[4].addr = BASE + DW;
        tbl[5].re = 1'b1; tbl[5].addr = BASE + DW;

        salt = $urandom;
        rst  = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_outputs", {scan_done, read_enable, address, pix_valid, pix_data, pix_last}, 0);
        tick(); rst = 1'b0;

        // Startup latency, address sequence, gap-free stream.
        d0 = done_cnt;
        tick(); scan_en = 1'b1; pix_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c > 0) begin tick(); scan_en = 1'b0; end
            @(negedge clk);
            chk($sformatf("t1_re[%0d]", c), read_enable, tbl[c].re);
            chk($sformatf("t1_addr[%0d]", c), address, tbl[c].addr);
            chk($sformatf("t1_valid[%0d]", c), pix_valid, tbl[c].valid);
            if (tbl[c].valid) chk($sformatf("t1_data[%0d]", c), pix_data, tbl[c].data);
        end
        cyc = 8;
        while (done_cnt == d0 && cyc < FRAME + 100) begin tick(); cyc++; end
        chk("t1_done_cycle", cyc - 1, FRAME + 4);
        chk("t1_frames", done_cnt - d0, 1);

        // Downstream stall: two blocks fetched, then hold until a buffer frees.
        data_mode = 1; salt = $urandom; pix_ready = 1'b0;
        start_scan();
        repeat (200) tick();
        chk("t3_blocks_fetched", req_cnt, 2);
        @(negedge clk);
        chk("t3_hold_no_req", read_enable, 0);
        chk("t3_valid_held", pix_valid, 1);
        chk("t3_first_pix", pix_data, exp_pix(0));
        tick(); pix_ready = 1'b1;
        repeat (63) tick();
        @(negedge clk);
        chk("t3_no_early_req", read_enable, 0);
        tick();
        @(negedge clk);
        chk("t3_resume_req", read_enable, 1);
        chk("t3_resume_addr", address, BASE + 2 * DW);
        wait_done(FRAME * 4, 1'b1);

        // Reset at beat 100, then clean restart.
        salt = $urandom; pix_ready = 1'b1; d0 = done_cnt;
        start_scan();
        n = 0;
        while (beat < 100 && n < 500) begin tick(); n++; end
        chk("t4_reached_beat100", beat, 100);
        rst = 1'b1;
        tick(); rst = 1'b0;
        @(negedge clk);
        chk("t4_outputs_zero", {scan_done, read_enable, address, pix_valid, pix_data, pix_last}, 0);
        repeat (50) tick();
        chk("t4_no_done_after_rst", done_cnt - d0, 0);
        start_scan();
        @(negedge clk);
        chk("t4_restart_re", read_enable, 1);
        chk("t4_restart_addr", address, BASE);
        wait_done(FRAME * 4, 1'b0);

        // scan_en pulses mid-frame are ignored.
        salt = $urandom; d0 = done_cnt;
        start_scan();
        repeat (300) begin tick(); pix_ready = ($urandom_range(3) != 0); end
        scan_en = 1'b1; tick(); scan_en = 1'b0;
        repeat (200) begin tick(); pix_ready = ($urandom_range(3) != 0); end
        scan_en = 1'b1; tick(); scan_en = 1'b0;
        wait_done(FRAME * 4, 1'b1);
        repeat (100) tick();
        chk("t5_single_done", done_cnt - d0, 1);
        chk("t5_no_restart", req_cnt, 0);

        // Byte order of a known word.
        data_mode = 2; pix_ready = 1'b0;
        start_scan();
        repeat (6) tick();
        @(negedge clk);
`ifdef SCANOUT_SWAP_RB_EN
        chk("t6_swap_pix", pix_data, 24'h332211);
`else
        chk("t6_swap_pix", pix_data, 24'h112233);
`endif
        wait_done(FRAME * 4, 1'b1);

        repeat (5) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
